wb_regfile: RTL

Writeback-side consumer of the Memory→Writeback pipeline register. It selects the writeback result, commits it to the 32-entry integer register file, and serves the two combinational Decode read ports. It also keeps a retired-instruction counter. It sits between the M/W register outputs and the Decode stage of the 5-stage core.

---
 rtl/wb_regfile.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile
// ----------------------------------------------------------------------------
// Writeback-stage consumer of the Memory->Writeback pipeline register.
// It selects the writeback result and commits it to the 32-entry integer
// register file. It also serves the two combinational Decode read ports and
// keeps a retired-instruction counter.
//
// Parameters:
//   XLEN   data width of registers and results
//   CNT_W  width of the retired-instruction counter (wraps silently)
//
// Ports:
//   clk_i           rising-edge clock for all state
//   rst_i           asynchronous, active-high reset (clears x1..x31, instret)
//   valid_w_i       W stage holds a real instruction (0 = bubble)
//   reg_write_w_i   register write enable from M/W
//   result_src_w_i  00 ALU, 01 load data, 10 PC+4, 11 ALU (reserved)
//   alu_result_w_i  ALU result
//   read_data_w_i   load data
//   pc_plus4_w_i    link value for jal/jalr
//   rd_w_i          destination register index
//   a1_d_i, a2_d_i  Decode read addresses
//   rd1_d_o, rd2_d_o  Decode read data (asynchronous reads, x0 reads 0)
//   result_w_o      selected writeback result, also used for forwarding
//   instret_o       registered retired-instruction count
//
// Build option:
//   WB_REGFILE_BYPASS_EN  when defined, a read of the register being written
//                         in the same cycle returns the new value
//                         (write-through). When undefined, the read returns
//                         the stored (old) value.
// ============================================================================
module wb_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_w_i,
    input  logic             reg_write_w_i,
    input  logic [1:0]       result_src_w_i,
    input  logic [XLEN-1:0]  alu_result_w_i,
    input  logic [XLEN-1:0]  read_data_w_i,
    input  logic [XLEN-1:0]  pc_plus4_w_i,
    input  logic [4:0]       rd_w_i,
    input  logic [4:0]       a1_d_i,
    input  logic [4:0]       a2_d_i,
    output logic [XLEN-1:0]  rd1_d_o,
    output logic [XLEN-1:0]  rd2_d_o,
    output logic [XLEN-1:0]  result_w_o,
    output logic [CNT_W-1:0] instret_o
);

    // ------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------
    logic [XLEN-1:0] result;

    always_comb begin
        result = alu_result_w_i;
        case (result_src_w_i)
            2'b00:   result = alu_result_w_i;
            2'b01:   result = read_data_w_i;
            2'b10:   result = pc_plus4_w_i;
            default: result = alu_result_w_i;  // 11 is reserved and aliases ALU
        endcase
    end

    assign result_w_o = result;

    // ------------------------------------------------------------------
    // Write enable: bubbles and x0 never write
    // ------------------------------------------------------------------
    logic rd_nonzero;
    logic we;

    assign rd_nonzero = (rd_w_i != 5'd0);
    assign we         = valid_w_i & reg_write_w_i & rd_nonzero;

    // ------------------------------------------------------------------
    // Storage: x0 has no flop, so only x1..x31 exist
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [1:31];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[rd_w_i] <= result;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rd1_stored;
    logic [XLEN-1:0] rd2_stored;

    always_comb begin
        rd1_stored = '0;
        if (a1_d_i != 5'd0) begin
            rd1_stored = regs_q[a1_d_i];
        end
    end

    always_comb begin
        rd2_stored = '0;
        if (a2_d_i != 5'd0) begin
            rd2_stored = regs_q[a2_d_i];
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    // Write-through: a same-cycle read of the destination sees the new value.
    // The x0 case stays safe because we is low whenever rd_w_i is 0.
    logic hit1;
    logic hit2;

    assign hit1 = we & (a1_d_i == rd_w_i);
    assign hit2 = we & (a2_d_i == rd_w_i);

    always_comb begin
        rd1_d_o = rd1_stored;
        if (hit1) begin
            rd1_d_o = result;
        end
    end

    always_comb begin
        rd2_d_o = rd2_stored;
        if (hit2) begin
            rd2_d_o = result;
        end
    end
`else
    // Reads see only stored contents. The hazard unit stalls or forwards
    // from result_w_o.
    assign rd1_d_o = rd1_stored;
    assign rd2_d_o = rd2_stored;
`endif

    // ------------------------------------------------------------------
    // Retired-instruction counter: every valid W instruction retires,
    // whether or not it writes a register.
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instret_q <= '0;
        end else if (valid_w_i) begin
            instret_q <= instret_q + CntOne;  // wraps to 0 without a flag
        end
    end

    assign instret_o = instret_q;

endmodule
